dbc_port_change_arbiter: RTL and testbench
==========================================

# dbc_port_change_arbiter

Latches the DbC port status-change pulses (CSC, PLC, PRC, CEC) into software-visible RW1C change bits. It arbitrates pending change notifications onto a single Port Status Change event interface with a valid/ready handshake. It also runs the enumeration watchdog that produces EnumError for the DbC port state machine. It sits between the DbC port state machine and the event ring writer.

## Interface
- `ENUM_TIMEOUT`, 1000: cycles allowed from enumeration start to `set_config_succesful`.
- `TMR_W`, 16: width of the watchdog counter; `ENUM_TIMEOUT` must be < 2^`TMR_W`.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `csc_set`, `plc_set`, `prc_set`, `cec_set`  in  1 each  one-cycle change pulses from the port state machine.
- `rw1c_clr`  in  4  software write-1-to-clear strobe; bit0 CSC, bit1 PLC, bit2 PRC, bit3 CEC.
- `change_bits`  out  4  current change bits, same bit order.
- `evt_valid`  out  1  event offered to the event ring writer.
- `evt_code`  out  2  event source: 0 CSC, 1 PLC, 2 PRC, 3 CEC.
- `evt_ready`  in  1  event ring writer accepts the event.
- `PED`  in  1  port enabled.
- `enum_start`  in  1  pulse: enumeration begins.
- `set_config_succesful`  in  1  pulse: enumeration finished.
- `EnumError`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- Change bit k sets on its set pulse and clears on `rw1c_clr[k]`. If both occur in the same cycle, the set wins.
- Pending flag k sets only on a 0→1 transition of change bit k. A set pulse while the bit is already 1 creates no new event. `rw1c_clr` never clears a pending flag.
- Arbiter FSM:
  - IDLE: if any pending flag is set, latch the winner index into `evt_code`, assert `evt_valid`, and go to OFFER.
  - OFFER: hold `evt_valid` and `evt_code` stable until a cycle with `evt_ready`=1. On that edge, clear the winner's pending flag, deassert `evt_valid`, and return to IDLE.
  - A source re-pending during OFFER, including the source being offered, is queued and not lost.
- Default arbitration is fixed priority: the lowest index wins (CSC > PLC > PRC > CEC).
- Watchdog FSM:
  - W_IDLE: `enum_start` with `PED`=1 loads the counter with 0 and goes to W_RUN. `enum_start` with `PED`=0 is ignored.
  - W_RUN: the counter increments each cycle.
    - `set_config_succesful` returns to W_IDLE with no error.
    - `PED`=0 aborts to W_IDLE with no error.
    - Counter reaching `ENUM_TIMEOUT`−1 with neither event pulses `EnumError` for one cycle and returns to W_IDLE.
  - If `set_config_succesful` arrives on the expiry cycle, success wins and no error is raised.
  - `enum_start` during W_RUN restarts the counter at 0.

## Timing
- Reset values: `change_bits`=0, pending=0, `evt_valid`=0, `evt_code`=0, `EnumError`=0. Both FSMs reset to their idle states.
- Reset is asynchronous mid-operation: an in-flight offer is dropped and the watchdog is cancelled.
- Set pulse sampled at edge N: the change bit is visible after N and `evt_valid` rises after edge N+1.
- With `evt_ready` held high, one event is accepted every 2 cycles. There is one mandatory IDLE cycle between offers.
- `EnumError` rises after the edge on which the counter equals `ENUM_TIMEOUT`−1. With `enum_start` at edge S, that edge is S+`ENUM_TIMEOUT`.
- All outputs are registered.

## Configuration
- `DBC_RR_ARB_EN` defined: round-robin arbitration. The search starts at the index after the last accepted event and wraps from 3 to 0. The pointer resets to 3, so CSC is searched first.
- Not defined: fixed priority as described above.

## Test plan
- Reset, then `csc_set` and `prc_set` pulsed together, `evt_ready`=1 → CSC event code 0 accepted, then code 2 two cycles later; `change_bits`=4'b0101.
- `plc_set` pulsed twice while the PLC bit stays set → exactly one code-1 event. Apply `rw1c_clr`=4'b0010, then `plc_set` → a second event.
- `evt_ready`=0 for 10 cycles during an offer → `evt_valid` and `evt_code` stay stable. `cec_set` meanwhile → CEC (code 3) is offered after the first offer is accepted.
- `ENUM_TIMEOUT`=20, `PED`=1, `enum_start`, no success → a single `EnumError` pulse 20 cycles later. Repeat with success at cycle 10 → no pulse. Repeat with `PED` dropped at cycle 5 → no pulse.
- `DBC_RR_ARB_EN`, all four sources pending continuously, `evt_ready`=1 → codes 0,1,2,3,0 in order. Without the macro → code 0 repeats whenever CSC re-pends.
- `reset` asserted while `evt_valid`=1 and the watchdog is running → all outputs are 0 immediately, and no `EnumError` follows.

Source files
------------

// File: rtl/dbc_port_change_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dbc_port_change_arbiter : latches DbC port change pulses into RW1C bits,
// arbitrates pending changes onto one event handshake, runs the enumeration
// watchdog. Define DBC_RR_ARB_EN for round-robin arbitration.
// Rev 1.0
// ---------------------------------------------------------------------------
module dbc_port_change_arbiter #(
  parameter int ENUM_TIMEOUT = 1000,
  parameter int TMR_W        = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       csc_set,
  input  logic       plc_set,
  input  logic       prc_set,
  input  logic       cec_set,
  input  logic [3:0] rw1c_clr,
  output logic [3:0] change_bits,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  input  logic       PED,
  input  logic       enum_start,
  input  logic       set_config_succesful,
  output logic       EnumError
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;
  localparam logic [0:0] W_IDLE  = 1'b0;
  localparam logic [0:0] W_RUN   = 1'b1;
  localparam logic [TMR_W-1:0] c_last_cnt = TMR_W'(ENUM_TIMEOUT - 1);

  logic [3:0] r_change;
  logic [3:0] r_pend;
  logic [3:0] w_set;
  logic [3:0] w_rise;
  logic [3:0] w_pend_clr;
  logic [0:0] r_arb_state;
  logic [0:0] w_arb_next;
  logic [1:0] r_code;
  logic [1:0] w_win;
  logic       w_found;
  logic       w_accept;
  logic       w_load;

  assign w_set  = {cec_set, prc_set, plc_set, csc_set};
  // Only a 0->1 edge of the change bit creates a new notification.
  assign w_rise = w_set & ~r_change;

`ifdef DBC_RR_ARB_EN
  logic [1:0] r_ptr;
  logic [1:0] w_idx;

  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && r_pend[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr <= 2'd3;
    end else if (w_accept) begin
      r_ptr <= r_code;
    end
  end
`else
  always_comb begin
    w_win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_win = 2'(i);
      end
    end
  end

  assign w_found = |r_pend;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_arb_state <= S_IDLE;
    end else begin
      r_arb_state <= w_arb_next;
    end
  end

  always_comb begin
    w_arb_next = r_arb_state;
    case (r_arb_state)
      S_IDLE:  if (w_found)   w_arb_next = S_OFFER;
      S_OFFER: if (evt_ready) w_arb_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load     = (r_arb_state == S_IDLE) && w_found;
    w_accept   = (r_arb_state == S_OFFER) && evt_ready;
    w_pend_clr = {3'b000, w_accept} << r_code;
  end

  // A re-pend of the accepted source on the accept edge survives the clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_change <= 4'h0;
      r_pend   <= 4'h0;
      r_code   <= 2'd0;
    end else begin
      r_change <= (r_change & ~rw1c_clr) | w_set;
      r_pend   <= (r_pend & ~w_pend_clr) | w_rise;
      if (w_load) begin
        r_code <= w_win;
      end
    end
  end

  assign change_bits = r_change;
  assign evt_valid   = r_arb_state;
  assign evt_code    = r_code;

  logic [0:0]       r_wd_state;
  logic [0:0]       w_wd_next;
  logic [TMR_W-1:0] r_cnt;
  logic [TMR_W-1:0] w_cnt_next;
  logic             r_enum_err;
  logic             w_err_next;
  logic             w_expire;

  assign w_expire = (r_cnt == c_last_cnt);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wd_state <= W_IDLE;
      r_cnt      <= '0;
      r_enum_err <= 1'b0;
    end else begin
      r_wd_state <= w_wd_next;
      r_cnt      <= w_cnt_next;
      r_enum_err <= w_err_next;
    end
  end

  always_comb begin
    w_wd_next = r_wd_state;
    case (r_wd_state)
      W_IDLE: if (enum_start && PED) w_wd_next = W_RUN;
      W_RUN: begin
        if (set_config_succesful || !PED) w_wd_next = W_IDLE;
        else if (enum_start)              w_wd_next = W_RUN;
        else if (w_expire)                w_wd_next = W_IDLE;
      end
    endcase
  end

  // Success and PED loss take precedence over expiry on the same cycle.
  always_comb begin
    w_cnt_next = r_cnt;
    w_err_next = 1'b0;
    case (r_wd_state)
      W_IDLE: if (enum_start && PED) w_cnt_next = '0;
      W_RUN: begin
        if (set_config_succesful || !PED) w_cnt_next = r_cnt;
        else if (enum_start)              w_cnt_next = '0;
        else if (w_expire)                w_err_next = 1'b1;
        else                              w_cnt_next = r_cnt + TMR_W'(1);
      end
    endcase
  end

  assign EnumError = r_enum_err;

endmodule
`default_nettype wire

// File: tb/tb_dbc_port_change_arbiter.sv
`default_nettype none
// Bench for dbc_port_change_arbiter: directed scenarios plus random traffic,
// every cycle compared against an event-level reference model.
module tb_dbc_port_change_arbiter;

  localparam int T = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       csc_set = 1'b0, plc_set = 1'b0, prc_set = 1'b0, cec_set = 1'b0;
  logic [3:0] rw1c_clr = 4'h0;
  logic [3:0] change_bits;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready = 1'b0;
  logic       PED = 1'b1;
  logic       enum_start = 1'b0;
  logic       set_config_succesful = 1'b0;
  logic       EnumError;

  always #5 clock = ~clock;

  dbc_port_change_arbiter #(.ENUM_TIMEOUT(T), .TMR_W(16)) dut (
    .clock(clock), .reset(reset),
    .csc_set(csc_set), .plc_set(plc_set), .prc_set(prc_set), .cec_set(cec_set),
    .rw1c_clr(rw1c_clr), .change_bits(change_bits),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
    .PED(PED), .enum_start(enum_start),
    .set_config_succesful(set_config_succesful), .EnumError(EnumError)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [3:0] m_cb = 4'h0;
  bit [3:0] m_pend = 4'h0;
  bit       m_off = 1'b0;
  int       m_code = 0;
  int       m_ptr = 3;
  bit       m_armed = 1'b0;
  bit       m_err = 1'b0;
  longint   cyc = 0;
  longint   deadline = 0;
  int       acc_log[$];
  bit [3:0] set_v, rise_v;

  function automatic int pick(bit [3:0] p, int ptr);
`ifdef DBC_RR_ARB_EN
    for (int k = 1; k <= 4; k++) if (p[(ptr + k) % 4]) return (ptr + k) % 4;
`else
    for (int k = 0; k < 4; k++) if (p[k]) return k;
`endif
    return 0;
  endfunction

  function automatic int count_code(int c);
    int n = 0;
    foreach (acc_log[i]) if (acc_log[i] == c) n++;
    return n;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_cb = 4'h0; m_pend = 4'h0; m_off = 1'b0; m_code = 0; m_ptr = 3;
      m_armed = 1'b0; m_err = 1'b0;
    end else begin
      cyc++;
      set_v  = {cec_set, prc_set, plc_set, csc_set};
      rise_v = set_v & ~m_cb;
      m_cb   = (m_cb & ~rw1c_clr) | set_v;
      if (m_off) begin
        if (evt_ready) begin
          m_pend[m_code] = 1'b0;
          m_off = 1'b0;
          m_ptr = m_code;
          acc_log.push_back(m_code);
        end
      end else if (m_pend != 4'h0) begin
        m_code = pick(m_pend, m_ptr);
        m_off  = 1'b1;
      end
      m_pend = m_pend | rise_v;

      // Watchdog as a deadline: error exactly T edges after the latest start.
      m_err = 1'b0;
      if (!m_armed) begin
        if (enum_start && PED) begin m_armed = 1'b1; deadline = cyc + T; end
      end else if (set_config_succesful || !PED) begin
        m_armed = 1'b0;
      end else if (enum_start) begin
        deadline = cyc + T;
      end else if (cyc == deadline) begin
        m_err = 1'b1; m_armed = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      check("change_bits", change_bits, m_cb);
      check("evt_valid", evt_valid, m_off);
      check("evt_code", evt_code, m_code[1:0]);
      check("EnumError", EnumError, m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clock);
    csc_set = 1'b0; plc_set = 1'b0; prc_set = 1'b0; cec_set = 1'b0;
    rw1c_clr = 4'h0; enum_start = 1'b0; set_config_succesful = 1'b0;
  endtask

  int n0;

  initial begin
    repeat (3) @(negedge clock);
    check("rst_change_bits", change_bits, 4'h0);
    check("rst_evt_valid", evt_valid, 1'b0);
    check("rst_EnumError", EnumError, 1'b0);
    reset = 1'b1;
    tick();
    check("post_rst_valid", evt_valid, 1'b0);
    check("post_rst_code", evt_code, 2'd0);

    // CSC and PRC together: CSC first, PRC two cycles later
    evt_ready = 1'b1;
    csc_set = 1'b1; prc_set = 1'b1;
    tick();
    check("s1_change_bits", change_bits, 4'b0101);
    tick();
    check("s1_first_valid", evt_valid, 1'b1);
    check("s1_first_code", evt_code, 2'd0);
    tick();
    check("s1_gap_valid", evt_valid, 1'b0);
    tick();
    check("s1_second_valid", evt_valid, 1'b1);
    check("s1_second_code", evt_code, 2'd2);
    tick();
    check("s1_done_valid", evt_valid, 1'b0);
    check("s1_bits_kept", change_bits, 4'b0101);
    rw1c_clr = 4'hF; tick(); tick();

    // PLC set twice while bit stays set -> one event; clear then set -> another
    n0 = count_code(1);
    plc_set = 1'b1; tick(); tick();
    plc_set = 1'b1; tick();
    repeat (4) tick();
    check("s2_single_event", count_code(1), n0 + 1);
    rw1c_clr = 4'b0010; tick();
    plc_set = 1'b1; tick();
    repeat (4) tick();
    check("s2_second_event", count_code(1), n0 + 2);
    rw1c_clr = 4'hF; tick(); tick();

    // Stalled offer stays stable; CEC queued behind it
    evt_ready = 1'b0;
    csc_set = 1'b1; tick(); tick();
    cec_set = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("s3_hold_valid", evt_valid, 1'b1);
      check("s3_hold_code", evt_code, 2'd0);
    end
    evt_ready = 1'b1;
    tick();
    check("s3_accept_valid", evt_valid, 1'b0);
    tick();
    check("s3_cec_valid", evt_valid, 1'b1);
    check("s3_cec_code", evt_code, 2'd3);
    tick();
    rw1c_clr = 4'hF; tick(); tick();

    // All sources re-pending every other cycle
    acc_log.delete();
    for (int k = 0; k < 10; k++) begin
      csc_set = 1'b1; plc_set = 1'b1; prc_set = 1'b1; cec_set = 1'b1;
      tick();
      rw1c_clr = 4'hF;
      tick();
    end
    repeat (12) tick();
    check("s4_log_size", acc_log.size() >= 5, 1);
    if (acc_log.size() >= 5) begin
`ifdef DBC_RR_ARB_EN
      for (int k = 0; k < 5; k++) check("s4_rr_order", acc_log[k], k % 4);
`else
      for (int k = 0; k < 5; k++) check("s4_fixed_order", acc_log[k], 0);
`endif
    end

    // Watchdog expiry, success, and PED abort
    PED = 1'b1;
    enum_start = 1'b1; tick();
    for (int k = 1; k <= 25; k++) begin
      tick();
      check("wd_expiry", EnumError, (k == T) ? 1 : 0);
    end
    enum_start = 1'b1; tick();
    for (int k = 1; k <= 25; k++) begin
      if (k == 10) set_config_succesful = 1'b1;
      tick();
      check("wd_success", EnumError, 1'b0);
    end
    enum_start = 1'b1; tick();
    for (int k = 1; k <= 25; k++) begin
      if (k == 5) PED = 1'b0;
      tick();
      check("wd_ped_abort", EnumError, 1'b0);
    end
    PED = 1'b1; tick();

    // Async reset during an offer with the watchdog running
    evt_ready = 1'b0;
    csc_set = 1'b1; tick(); tick();
    enum_start = 1'b1; tick();
    repeat (5) tick();
    check("pre_reset_valid", evt_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("areset_change_bits", change_bits, 4'h0);
    check("areset_valid", evt_valid, 1'b0);
    check("areset_code", evt_code, 2'd0);
    check("areset_EnumError", EnumError, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      check("post_areset_no_error", EnumError, 1'b0);
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      csc_set    = ($urandom % 4) == 0;
      plc_set    = ($urandom % 4) == 0;
      prc_set    = ($urandom % 5) == 0;
      cec_set    = ($urandom % 5) == 0;
      rw1c_clr   = (($urandom % 3) == 0) ? 4'($urandom) : 4'h0;
      evt_ready  = ($urandom % 2) == 0;
      PED        = ($urandom % 64) != 0;
      enum_start = ($urandom % 40) == 0;
      set_config_succesful = ($urandom % 60) == 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
